serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have exactly one parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with the ports listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands a/b present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  minuend, unsigned.
REQ-008 b  input  WIDTH  subtrahend, unsigned.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-012 borrow_out  output  1  final borrow, 1 iff a < b unsigned.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 in IDLE and 0 in SHIFT and DONE; it is decoded from state only.
REQ-015 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; it SHALL latch a and b, clear the borrow and the bit counter, and enter SHIFT.
REQ-016 In SHIFT, each edge SHALL process one bit, LSB first, using full-subtractor logic: d = a0^b0^bor; bor' = (~a0&b0) | (~(a0^b0)&bor).
REQ-017 Each SHIFT edge SHALL shift d into the result MSB, shift the a/b shadow registers right by one, and increment the counter.
REQ-018 On the edge that processes bit WIDTH-1, the FSM SHALL enter DONE; out_valid SHALL therefore rise exactly WIDTH edges after the accepting edge.
REQ-019 In DONE, out_valid SHALL be 1, and diff and borrow_out SHALL be held stable until the handshake completes.
REQ-020 A DONE edge with out_ready=1 SHALL complete the handshake: the FSM returns to IDLE and out_valid drops on that edge.
REQ-021 Operands presented with in_valid=1 while the FSM is in DONE (with or without out_ready) SHALL NOT be accepted; acceptance is possible only from the following IDLE cycle (no back-to-back overlap).
REQ-022 Changes on a, b or in_valid during SHIFT or DONE SHALL have no effect on the operation in flight.
REQ-023 out_ready while not in DONE SHALL be ignored.
REQ-024 diff and borrow_out SHALL retain their last values in IDLE and SHIFT, while out_valid=0.
REQ-025 For WIDTH=1, the block SHALL behave as a registered half subtractor with 1-cycle processing.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force state to IDLE, out_valid=0, diff=0, borrow_out=0, the counter and shadow registers to 0, and in_ready=1.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result produced; the first accept after rst_n rises SHALL behave as from power-up.

Verification
REQ-028 a=8'h05, b=8'h03, out_ready=1 -> out_valid high 8 edges after accept, diff=8'h02, borrow_out=0; in_ready=1 on the next cycle.
REQ-029 a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; a=b=8'hA5 -> diff=8'h00, borrow_out=0.
REQ-030 out_ready held 0 for 5 cycles in DONE with in_valid=1 and a/b toggling -> out_valid, diff and borrow_out stable, no accept; result consumed on the first out_ready=1 edge.
REQ-031 rst_n pulsed low after the 3rd SHIFT edge -> out_valid=0, diff=0, in_ready=1 asynchronously; a new op a=8'h10, b=8'h01 then yields diff=8'h0F.
REQ-032 Random back-to-back operands (≥1000) with random out_ready stalls -> every result matches (a-b) mod 256 and the borrow rule; no lost or duplicated results.
REQ-033 WIDTH=1 exhaustive {00,01,10,11} -> (diff, borrow_out) = (0,0), (1,1), (1,0), (0,0).

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor with valid/ready handshakes.
// Operands are captured in IDLE, one bit per clock is processed LSB first in
// SHIFT, and the result is held in DONE until the consumer takes it.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // A 1-bit operand still needs a 1-bit counter so the compare stays legal.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             bor;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             bor_next;
    logic [WIDTH-1:0] acc_next;

    // Only IDLE can take new operands, so readiness is a pure state decode.
    assign in_ready = (state == IDLE);

    // Full-subtractor slice on the current LSBs and the partial result after this bit.
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ bor;
        bor_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
        acc_next = (acc >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    end

    // Handshake FSM plus datapath; diff/borrow_out only change on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        bor   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= acc_next;
                    bor  <= bor_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        diff       <= acc_next;
                        borrow_out <= bor_next;
                        out_valid  <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor
// at WIDTH=8 and WIDTH=1 against plain-arithmetic expectations.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow_out;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] diff1;
    logic       borrow_out1;

    int compared;
    int mismatched;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow_out(borrow_out1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One full WIDTH=8 operation: accept, wait for the result, stall, consume.
    task automatic apply_stimulus(input logic [7:0] a_v, input logic [7:0] b_v,
                                  input int stall, input bit scramble);
        logic [7:0] exp_d;
        logic       exp_b;
        int         edges;
        exp_d = a_v - b_v;
        exp_b = (a_v < b_v);
        check_output("in_ready_idle", in_ready, 1);
        a         = a_v;
        b         = b_v;
        in_valid  = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check_output("in_ready_shift", in_ready, 0);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            if (scramble) begin
                a         = 8'($urandom);
                b         = 8'($urandom);
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        check_output("latency", edges, 8);
        check_output("diff", diff, exp_d);
        check_output("borrow", borrow_out, exp_b);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = 8'($urandom);
            b         = 8'($urandom);
            @(posedge clk); #1;
            check_output("stall_valid", out_valid, 1);
            check_output("stall_diff", diff, exp_d);
            check_output("stall_borrow", borrow_out, exp_b);
            check_output("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'($urandom);
        b         = 8'($urandom);
        @(posedge clk); #1;
        check_output("consumed_valid", out_valid, 0);
        check_output("no_accept_in_done", in_ready, 1);
        check_output("hold_diff_idle", diff, exp_d);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // One WIDTH=1 operation on the second instance.
    task automatic apply_stimulus_w1(input logic a_v, input logic b_v);
        int   edges;
        logic exp_d;
        logic exp_b;
        exp_d = a_v ^ b_v;
        exp_b = (a_v < b_v);
        a1         = a_v;
        b1         = b_v;
        in_valid1  = 1'b1;
        out_ready1 = 1'b0;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        edges = 0;
        while (out_valid1 !== 1'b1 && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        check_output("w1_latency", edges, 1);
        check_output("w1_diff", diff1, exp_d);
        check_output("w1_borrow", borrow_out1, exp_b);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        check_output("w1_consumed", out_valid1, 0);
        out_ready1 = 1'b0;
    endtask

    // Main sequence: reset, directed cases, stall, mid-op reset, random, WIDTH=1.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        #3;
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_diff", diff, 0);
        check_output("rst_borrow", borrow_out, 0);
        check_output("rst_w1_in_ready", in_ready1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(8'h05, 8'h03, 0, 1'b0);
        apply_stimulus(8'h00, 8'h01, 0, 1'b1);
        apply_stimulus(8'hA5, 8'hA5, 1, 1'b1);
        apply_stimulus(8'h3C, 8'h5A, 5, 1'b1);

        // Abort mid-SHIFT with an asynchronous reset pulse.
        a        = 8'h33;
        b        = 8'h11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", out_valid, 0);
        check_output("async_rst_diff", diff, 0);
        check_output("async_rst_borrow", borrow_out, 0);
        check_output("async_rst_in_ready", in_ready, 1);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(8'h10, 8'h01, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            apply_stimulus(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            apply_stimulus_w1(ab[1], ab[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
